// File: rtl/frame_bank_if.sv
// Bus bundle for frame_bank_scheduler: the camera/VGA timing inputs and the
// bank-selection, recovery and statistics outputs.
// The slave modport belongs to the scheduler; the master modport belongs to
// whatever drives the timing signals and consumes the outputs.
interface frame_bank_if;
    logic        cam_vsync;
    logic        config_finished;
    logic        vga_frame_start;
    logic        freeze;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        wr_enable;
    logic        cfg_resend;
    logic        cam_alive;
    logic [15:0] frame_count;
    logic [15:0] dropped_count;

    modport master (
        output cam_vsync, config_finished, vga_frame_start, freeze,
        input  wr_bank, rd_bank, wr_enable, cfg_resend, cam_alive,
               frame_count, dropped_count
    );

    modport slave (
        input  cam_vsync, config_finished, vga_frame_start, freeze,
        output wr_bank, rd_bank, wr_enable, cfg_resend, cam_alive,
               frame_count, dropped_count
    );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler for the camera-to-VGA path (25 MHz video clock).
// The camera writer, the VGA reader and the last completed frame each own one
// of three banks. Banks rotate only on frame boundaries, so the display never
// tears. A watchdog asks for camera reprogramming if frames stop arriving.
// Optional feature: define FRAME_FREEZE_EN to let `freeze` hold the
// displayed bank. Without it, `freeze` is ignored.
module frame_bank_scheduler #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int RESEND_LEN     = 16
) (
    input  logic           clk,
    input  logic           rst,
    frame_bank_if.slave    bus
);
    localparam logic [1:0] ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] ST_SYNC     = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int RS_W = $clog2(RESEND_LEN + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RS_W-1:0] RS_LEN  = RS_W'(RESEND_LEN);

    logic [1:0]      state;
    logic            vsync_q;
    logic [1:0]      ready_bank;
    logic            ready_valid;
    logic [1:0]      free_bank;
    logic [WD_W-1:0] wd_cnt;
    logic [RS_W-1:0] resend_cnt;

    logic            vs_rise;
    logic            complete;
    logic            timeout;
    logic            frozen;
    logic [1:0]      nx_wr, nx_rd, nx_ready, nx_free;
    logic            nx_rv;

`ifdef FRAME_FREEZE_EN
    assign frozen = bus.freeze;
`else
    logic unused_freeze;
    assign unused_freeze = bus.freeze;
    assign frozen        = 1'b0;
`endif

    assign vs_rise  = bus.cam_vsync & ~vsync_q;
    assign complete = vs_rise && (state == ST_CAPTURE);
    // A frame edge arriving on the last watchdog cycle proves the camera is alive.
    assign timeout  = (state != ST_WAIT_CFG) && (wd_cnt == WD_LAST) && !vs_rise;

    // Next bank assignment: completion is applied first, then a swap may take the fresh frame.
    always_comb begin
        nx_wr    = bus.wr_bank;
        nx_rd    = bus.rd_bank;
        nx_ready = ready_bank;
        nx_free  = free_bank;
        nx_rv    = ready_valid;
        if (complete) begin
            nx_ready = bus.wr_bank;
            nx_rv    = 1'b1;
            nx_wr    = ready_valid ? ready_bank : free_bank;
        end
        if (bus.vga_frame_start && !frozen && nx_rv) begin
            nx_rd   = nx_ready;
            nx_free = bus.rd_bank;
            nx_rv   = 1'b0;
        end
    end

    // Control FSM, watchdog, resend pulse and camera-alive flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_WAIT_CFG;
            vsync_q       <= 1'b0;
            wd_cnt        <= '0;
            resend_cnt    <= '0;
            bus.wr_enable <= 1'b0;
            bus.cfg_resend <= 1'b0;
            bus.cam_alive <= 1'b0;
        end else begin
            vsync_q <= bus.cam_vsync;

            if (vs_rise || state == ST_WAIT_CFG || timeout)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;

            if (timeout) begin
                resend_cnt     <= RS_LEN;
                bus.cfg_resend <= 1'b1;
            end else if (resend_cnt != '0) begin
                resend_cnt     <= resend_cnt - 1'b1;
                bus.cfg_resend <= (resend_cnt > RS_W'(1));
            end

            if (complete)
                bus.cam_alive <= 1'b1;

            if (timeout) begin
                state         <= ST_WAIT_CFG;
                bus.wr_enable <= 1'b0;
                bus.cam_alive <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_CFG: if (bus.config_finished && resend_cnt == '0) state <= ST_SYNC;
                    ST_SYNC: begin
                        if (vs_rise) begin
                            state         <= ST_CAPTURE;
                            bus.wr_enable <= 1'b1;
                        end
                    end
                    ST_CAPTURE: ;
                    default: begin
                        state         <= ST_WAIT_CFG;
                        bus.wr_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bank ownership registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_bank <= 2'd0;
            bus.rd_bank <= 2'd2;
            free_bank   <= 2'd1;
            ready_bank  <= 2'd0;
            ready_valid <= 1'b0;
        end else begin
            bus.wr_bank <= nx_wr;
            bus.rd_bank <= nx_rd;
            free_bank   <= nx_free;
            ready_bank  <= nx_ready;
            ready_valid <= nx_rv;
        end
    end

    // Frame statistics: completed frames wrap, dropped frames saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.frame_count   <= '0;
            bus.dropped_count <= '0;
        end else if (complete) begin
            bus.frame_count <= bus.frame_count + 16'd1;
            if (ready_valid && bus.dropped_count != 16'hFFFF)
                bus.dropped_count <= bus.dropped_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: a vector table for the bank
// rotation, then hand-written sequences for freeze, watchdog and async reset.
module tb_frame_bank_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    frame_bank_if bus();

    frame_bank_scheduler #(.TIMEOUT_CYCLES(100), .RESEND_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic vs;
        logic vfs;
        logic cfg;
        int   wr;
        int   rd;
        int   en;
        int   alive;
        int   fc;
        int   dc;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame_pulse(input logic with_vfs);
        bus.cam_vsync = 1'b1;
        tick();
        bus.cam_vsync = 1'b0;
        bus.vga_frame_start = with_vfs;
        tick();
        bus.vga_frame_start = 1'b0;
    endtask

    initial begin
        int n;
        int h;
        int saved_wr;
        int saved_rd;
        int saved_fc;

        //             vs vfs cfg  wr rd en al fc dc
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 2, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 0, 2, 1, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 0, 2, 1, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1, 2, 1, 1, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1, 2, 1, 1, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 0, 2, 1, 1, 2, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 0, 1, 1, 1, 2, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2, 1, 1, 1, 3, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1, 1, 3, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2, 0, 1, 1, 3, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1, 2, 1, 1, 4, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1, 2, 1, 1, 4, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 0, 2, 1, 1, 5, 1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 0, 2, 1, 1, 5, 1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1, 0, 1, 1, 6, 2};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1, 0, 1, 1, 6, 2};

        bus.cam_vsync       = 1'b0;
        bus.config_finished = 1'b0;
        bus.vga_frame_start = 1'b0;
        bus.freeze          = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("reset_wr_bank",    int'(bus.wr_bank), 0);
        chk("reset_rd_bank",    int'(bus.rd_bank), 2);
        chk("reset_wr_enable",  int'(bus.wr_enable), 0);
        chk("reset_cfg_resend", int'(bus.cfg_resend), 0);
        chk("reset_cam_alive",  int'(bus.cam_alive), 0);
        chk("reset_frame_cnt",  int'(bus.frame_count), 0);
        chk("reset_drop_cnt",   int'(bus.dropped_count), 0);

        // Bank rotation table
        for (int i = 0; i < 16; i++) begin
            bus.cam_vsync       = tbl[i].vs;
            bus.vga_frame_start = tbl[i].vfs;
            bus.config_finished = tbl[i].cfg;
            tick();
            chk($sformatf("row%0d_wr_bank", i),   int'(bus.wr_bank), tbl[i].wr);
            chk($sformatf("row%0d_rd_bank", i),   int'(bus.rd_bank), tbl[i].rd);
            chk($sformatf("row%0d_wr_enable", i), int'(bus.wr_enable), tbl[i].en);
            chk($sformatf("row%0d_cam_alive", i), int'(bus.cam_alive), tbl[i].alive);
            chk($sformatf("row%0d_frame_cnt", i), int'(bus.frame_count), tbl[i].fc);
            chk($sformatf("row%0d_drop_cnt", i),  int'(bus.dropped_count), tbl[i].dc);
            chk($sformatf("row%0d_distinct", i),  int'(bus.wr_bank != bus.rd_bank && bus.wr_bank <= 2'd2 && bus.rd_bank <= 2'd2), 1);
        end
        bus.cam_vsync       = 1'b0;
        bus.vga_frame_start = 1'b0;

        // Freeze: four frames, each followed by a VGA frame start
        bus.freeze = 1'b1;
`ifdef FRAME_FREEZE_EN
        for (int k = 0; k < 4; k++) begin
            frame_pulse(1'b1);
            chk($sformatf("freeze%0d_rd_held", k), int'(bus.rd_bank), 0);
        end
        chk("freeze_drop_cnt", int'(bus.dropped_count), 5);
`else
        for (int k = 0; k < 4; k++) begin
            frame_pulse(1'b1);
            chk($sformatf("nofreeze%0d_rd_bank", k), int'(bus.rd_bank), (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 0 : 1);
        end
        chk("nofreeze_drop_cnt", int'(bus.dropped_count), 2);
`endif
        chk("freeze_frame_cnt", int'(bus.frame_count), 10);
        bus.freeze = 1'b0;
        bus.vga_frame_start = 1'b1;
        tick();
        bus.vga_frame_start = 1'b0;
`ifdef FRAME_FREEZE_EN
        chk("release_rd_bank", int'(bus.rd_bank), 2);
        chk("release_wr_bank", int'(bus.wr_bank), 1);
`else
        chk("release_rd_bank", int'(bus.rd_bank), 1);
        chk("release_wr_bank", int'(bus.wr_bank), 2);
`endif

        // Watchdog: one frame, then silence
        bus.config_finished = 1'b0;
        bus.cam_vsync = 1'b1;
        tick();
        bus.cam_vsync = 1'b0;
        saved_wr = int'(bus.wr_bank);
        saved_rd = int'(bus.rd_bank);
        saved_fc = int'(bus.frame_count);
        n = 0;
        while (!bus.cfg_resend && n < 300) begin
            tick();
            n++;
        end
        chk("wd_timeout_cycles", n, 100);
        chk("wd_wr_enable",      int'(bus.wr_enable), 0);
        chk("wd_cam_alive",      int'(bus.cam_alive), 0);
        h = 0;
        while (bus.cfg_resend && h < 50) begin
            tick();
            h++;
        end
        chk("wd_resend_len",  h, 16);
        chk("wd_wr_retained", int'(bus.wr_bank), saved_wr);
        chk("wd_rd_retained", int'(bus.rd_bank), saved_rd);
        chk("wd_fc_retained", int'(bus.frame_count), saved_fc);

        // Recovery: config done -> SYNC, first edge only enters CAPTURE
        bus.config_finished = 1'b1;
        tick();
        chk("recover_sync_wr_enable", int'(bus.wr_enable), 0);
        bus.cam_vsync = 1'b1;
        tick();
        bus.cam_vsync = 1'b0;
        chk("recover_capture_wr_enable", int'(bus.wr_enable), 1);
        chk("recover_frame_cnt",         int'(bus.frame_count), saved_fc);
        tick();
        frame_pulse(1'b0);
        chk("recover_cam_alive", int'(bus.cam_alive), 1);

        // Asynchronous reset mid-capture
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_wr_bank",    int'(bus.wr_bank), 0);
        chk("arst_rd_bank",    int'(bus.rd_bank), 2);
        chk("arst_wr_enable",  int'(bus.wr_enable), 0);
        chk("arst_cfg_resend", int'(bus.cfg_resend), 0);
        chk("arst_cam_alive",  int'(bus.cam_alive), 0);
        chk("arst_frame_cnt",  int'(bus.frame_count), 0);
        chk("arst_drop_cnt",   int'(bus.dropped_count), 0);
        tick();
        rst = 1'b0;
        bus.vga_frame_start = 1'b1;
        tick();
        bus.vga_frame_start = 1'b0;
        chk("arst_no_pending_swap", int'(bus.rd_bank), 2);
        chk("arst_still_idle",      int'(bus.wr_enable), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
